// File: rtl/ha_array_seq_accum_if.sv
// Requester/consumer handshake bundle for ha_array_seq_accum: operand pair in, approximate product out.
// The slave modport is the controller's view; the master modport is the requester/consumer view.
interface ha_array_seq_accum_if #(
  parameter int W  = 8,
  parameter int PW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_x;
  logic [W-1:0]  in_y;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_p;

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_p
  );

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_p
  );
endinterface

// File: rtl/ha_array_seq_accum.sv
// Sequential accumulator for the 8x8 approximate half-adder-array generator; one row group per cycle, product after NGRP+1 edges.
// Holds the product in DONE until out_ready; no bypass into IDLE. ZERO_SKIP_EN enables early exit on all-zero upper groups.
module ha_array_seq_accum #(
  parameter int W    = 8,
  parameter int NGRP = 4,
  parameter int TW   = 9,
  parameter int BW   = 7,
  parameter int PW   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  ha_array_seq_accum_if.slave  bus,
  output logic [W-1:0]         o_gen_x,
  output logic [W-1:0]         o_gen_y,
  input  logic [NGRP*TW-1:0]   i_gen_t,
  input  logic [NGRP*BW-1:0]   i_gen_b,
  output logic                 o_busy
);

  localparam int GW = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic [PW-1:0] r_acc;
  logic [GW-1:0] r_grp;

  logic [TW-1:0] w_t_k;
  logic [BW-1:0] w_b_k;
  logic [GW:0]   w_sh_t;
  logic [GW+1:0] w_sh_b;
  logic [PW-1:0] w_t_ext;
  logic [PW-1:0] w_b_ext;
  logic [PW-1:0] w_addend;
  logic          w_last;

  // Current group's vectors, weighted by 2^(2k) for t and 2^(2k+2) for b
  assign w_t_k    = i_gen_t[r_grp*TW +: TW];
  assign w_b_k    = i_gen_b[r_grp*BW +: BW];
  assign w_sh_t   = {r_grp, 1'b0};
  assign w_sh_b   = {1'b0, w_sh_t} + (GW+2)'(2);
  assign w_t_ext  = PW'(w_t_k);
  assign w_b_ext  = PW'(w_b_k);
  assign w_addend = (w_t_ext << w_sh_t) + (w_b_ext << w_sh_b);

`ifdef ZERO_SKIP_EN
  logic w_rest_zero;

  always_comb begin
    w_rest_zero = 1'b1;
    for (int g = 0; g < NGRP; g++) begin
      if ((g > int'(r_grp)) && ((|i_gen_t[g*TW +: TW]) || (|i_gen_b[g*BW +: BW]))) begin
        w_rest_zero = 1'b0;
      end
    end
  end

  assign w_last = (r_grp == GW'(NGRP-1)) || w_rest_zero;
`else
  assign w_last = (r_grp == GW'(NGRP-1));
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_nxt = S_ACC;
      S_ACC:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_acc <= '0;
      r_grp <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_x   <= bus.in_x;
            r_y   <= bus.in_y;
            r_acc <= '0;
            r_grp <= '0;
          end
        end
        S_ACC: begin
          // Sum is truncated to PW bits; carries out of the top bit are dropped
          r_acc <= r_acc + w_addend;
          if (!w_last) r_grp <= r_grp + GW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_p     = r_acc;
  assign o_busy        = (r_state != S_IDLE);
  assign o_gen_x       = r_x;
  assign o_gen_y       = r_y;

endmodule

// File: tb/tb_ha_array_seq_accum.sv
// Directed bench for ha_array_seq_accum with a stub generator and a queue-based scoreboard.
module tb_ha_array_seq_accum;
  localparam int W = 8, NGRP = 4, TW = 9, BW = 7, PW = 16;
`ifdef ZERO_SKIP_EN
  localparam int LAT_G0 = 2, LAT_G1 = 3, B2B_SP = 4;
`else
  localparam int LAT_G0 = 5, LAT_G1 = 5, B2B_SP = 6;
`endif
  localparam int LAT_FULL = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ha_array_seq_accum_if #(.W(W), .PW(PW)) bus ();
  logic [W-1:0]       gen_x, gen_y;
  logic [NGRP*TW-1:0] gen_t;
  logic [NGRP*BW-1:0] gen_b;
  logic               busy;

  ha_array_seq_accum #(.W(W), .NGRP(NGRP), .TW(TW), .BW(BW), .PW(PW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus),
    .o_gen_x (gen_x),
    .o_gen_y (gen_y),
    .i_gen_t (gen_t),
    .i_gen_b (gen_b),
    .o_busy  (busy)
  );

  // Stub generator: static vectors, or t0 = {0,x} and b1 = y[6:0]
  logic               stub_mode;
  logic [NGRP*TW-1:0] st_t;
  logic [NGRP*BW-1:0] st_b;
  always_comb begin
    gen_t = st_t;
    gen_b = st_b;
    if (stub_mode) begin
      gen_t = '0;
      gen_b = '0;
      gen_t[TW-1:0]   = {1'b0, gen_x};
      gen_b[BW +: BW] = gen_y[BW-1:0];
    end
  end

  typedef struct { logic [PW-1:0] p; int lat; } exp_t;
  exp_t q[$];
  int   hs_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   lat_done = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, pops expectations on handshake
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        acc_cyc  = cyc + 1;
        lat_done = 1'b0;
      end
      if (bus.out_valid !== 1'b0) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("busy_in_done", 32'(busy), 32'd1);
          if (!lat_done) begin
            chk("latency", cyc - acc_cyc + 1, q[0].lat);
            lat_done = 1'b1;
          end
          if (bus.out_ready === 1'b1) begin
            chk("product", 32'(bus.out_p), 32'(q[0].p));
            void'(q.pop_front());
            hs_cyc.push_back(cyc);
          end else begin
            chk("held_product", 32'(bus.out_p), 32'(q[0].p));
            chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
          end
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [PW-1:0] p, input int lat);
    int i;
    i = 0;
    while (bus.in_ready !== 1'b1 && i < 30) begin
      @(posedge clk); #1;
      i++;
    end
    if (bus.in_ready !== 1'b1) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_valid = 1'b1;
    q.push_back('{p, lat});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_x     = ~x;
    bus.in_y     = ~y;
    chk("gen_x_latched", 32'(gen_x), 32'(x));
    chk("gen_y_latched", 32'(gen_y), 32'(y));
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (q.size() != 0 && i < 40) begin
      @(posedge clk);
      i++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    #1;
  endtask

  logic [W-1:0]  px [3];
  logic [W-1:0]  py [3];
  logic [PW-1:0] pp [3];

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b1;
    stub_mode     = 1'b0;
    st_t          = '0;
    st_b          = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_p", 32'(bus.out_p), 32'd0);
    chk("rst_gen_x", 32'(gen_x), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single group: t0 bit 0 only
    st_t = '0; st_t[0] = 1'b1; st_b = '0;
    issue(8'h11, 8'h22, 16'h0001, LAT_G0);
    drain();

    // Top group full: 0x1FF<<6 + 0x7F<<8
    st_t = '0; st_b = '0;
    st_t[3*TW +: TW] = 9'h1FF;
    st_b[3*BW +: BW] = 7'h7F;
    issue(8'hC3, 8'h5A, 16'hFEC0, LAT_FULL);
    drain();

    // All groups full: 86615 mod 65536
    st_t = {NGRP{9'h1FF}};
    st_b = {NGRP{7'h7F}};
    issue(8'hFF, 8'hFF, 16'h5257, LAT_FULL);
    drain();

    // Reset in the 2nd ACC cycle discards the operation
    bus.in_x = 8'h33; bus.in_y = 8'h44; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("busy_mid_acc", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_p", 32'(bus.out_p), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Backpressure: group1 t=5 -> 20
    st_t = '0; st_b = '0;
    st_t[TW +: TW] = 9'h005;
    bus.out_ready = 1'b0;
    issue(8'h01, 8'h02, 16'h0014, LAT_G1);
    begin
      int i;
      i = 0;
      while (bus.out_valid !== 1'b1 && i < 20) begin
        @(negedge clk);
        i++;
      end
      chk("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    bus.in_x = 8'hAA; bus.in_y = 8'hBB; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("bp_pulse_ignored", 32'(gen_x), 32'h01);
    @(posedge clk); #1;

    // Back-to-back with a data-dependent stub: p = x + (y[6:0] << 4)
    stub_mode = 1'b1;
    hs_cyc.delete();
    px[0] = 8'h12; py[0] = 8'h03; pp[0] = 16'h0042;
    px[1] = 8'hFF; py[1] = 8'h7F; pp[1] = 16'h08EF;
    px[2] = 8'h80; py[2] = 8'h81; pp[2] = 16'h0090;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int t;
      bus.in_x = px[k];
      bus.in_y = py[k];
      q.push_back('{pp[k], LAT_G1});
      t = 0;
      while (bus.in_ready !== 1'b1 && t < 30) begin
        @(posedge clk); #1;
        t++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    drain();
    chk("b2b_count", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_spacing01", hs_cyc[1] - hs_cyc[0], B2B_SP);
      chk("b2b_spacing12", hs_cyc[2] - hs_cyc[1], B2B_SP);
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
